// File: rtl/pid_pwm_pkg.sv
// Shared widths, default timing constants and the arming state type for the
// altitude throttle PWM stage.
package pid_pwm_pkg;

  localparam int unsigned PID_W  = 15;
  localparam int unsigned CNT_W  = 18;
  localparam int unsigned PROD_W = 32;

  localparam int unsigned DefPeriodCycles   = 250000;
  localparam int unsigned DefMinPulseCycles = 100000;
  localparam int unsigned DefMaxPulseCycles = 200000;
  localparam int unsigned DefTimeoutPeriods = 8;

  typedef enum logic [1:0] {
    StDisarmed,
    StArmed,
    StFailsafe
  } state_e;

  function automatic logic [CNT_W-1:0] clamp_width(input logic [PROD_W-1:0] sum,
                                                    input logic [PROD_W-1:0] ceiling);
    logic [PROD_W-1:0] sel;
    sel = (sum > ceiling) ? ceiling : sum;
    return CNT_W'(sel);
  endfunction

endpackage

// File: rtl/pwm_scale.sv
// Maps a PID command onto a pulse width: the product is registered here and the
// shift/offset/clamp result is captured by the caller's pending-width register.
module pwm_scale
  import pid_pwm_pkg::*;
#(
  parameter int unsigned MinPulse = DefMinPulseCycles,
  parameter int unsigned MaxPulse = DefMaxPulseCycles
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [PID_W-1:0] pid_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] width_o
);

  localparam logic [PROD_W-1:0] Span = PROD_W'(MaxPulse - MinPulse);

  logic [PROD_W-1:0] prod_q;
  logic              valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= PROD_W'(pid_i) * Span;
      end
    end
  end

  assign valid_o = valid_q;
  assign width_o = clamp_width(PROD_W'(MinPulse) + (prod_q >> PID_W), PROD_W'(MaxPulse));

endmodule

// File: rtl/altitude_throttle_pwm.sv
// ESC throttle pulse generator: period counter, boundary-aligned width adoption,
// arming state machine and command-loss watchdog.
module altitude_throttle_pwm
  import pid_pwm_pkg::*;
#(
  parameter int unsigned PWM_PERIOD_CYCLES = DefPeriodCycles,
  parameter int unsigned MIN_PULSE_CYCLES  = DefMinPulseCycles,
  parameter int unsigned MAX_PULSE_CYCLES  = DefMaxPulseCycles,
  parameter int unsigned TIMEOUT_PERIODS   = DefTimeoutPeriods
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sink_data_valid,
  input  logic [PID_W-1:0] sink_pid,
  input  logic             sink_arm,
  output logic             pwm_out,
  output logic             source_period_start,
  output logic             failsafe
);

  localparam int unsigned WdW = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PWM_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MinWidth   = CNT_W'(MIN_PULSE_CYCLES);
  localparam logic [WdW-1:0]   WdLimit    = WdW'(TIMEOUT_PERIODS);

  if (MIN_PULSE_CYCLES >= MAX_PULSE_CYCLES || MAX_PULSE_CYCLES >= PWM_PERIOD_CYCLES ||
      PWM_PERIOD_CYCLES > (1 << CNT_W) || TIMEOUT_PERIODS == 0) begin : g_bad_params
    $error("altitude_throttle_pwm: need MIN < MAX < PERIOD <= 2**CNT_W and TIMEOUT > 0");
  end

  state_e           state_q;
  logic             started_q;
  logic             seen_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q;
  logic [WdW-1:0]   wd_q;
  logic             start_d;
  logic             pwm_d;
  logic             scale_valid;
  logic [CNT_W-1:0] scale_width;

  pwm_scale #(
    .MinPulse (MIN_PULSE_CYCLES),
    .MaxPulse (MAX_PULSE_CYCLES)
  ) u_scale (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (sink_data_valid),
    .pid_i   (sink_pid),
    .valid_o (scale_valid),
    .width_o (scale_width)
  );

  // The first edge after reset release presents counter 0 without advancing.
  always_comb begin
    start_d = !started_q || (cnt_q == PeriodLast);
    cnt_d   = start_d ? '0 : cnt_q + CNT_W'(1);
    act_d   = act_q;
    if (start_d) begin
      act_d = (state_q == StArmed) ? pend_q : MinWidth;
    end
    pwm_d = cnt_d < act_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q           <= 1'b0;
      seen_valid_q        <= 1'b0;
      cnt_q               <= '0;
      act_q               <= MinWidth;
      pend_q              <= MinWidth;
      wd_q                <= '0;
      pwm_out             <= 1'b0;
      source_period_start <= 1'b0;
    end else begin
      started_q           <= 1'b1;
      cnt_q               <= cnt_d;
      act_q               <= act_d;
      pwm_out             <= pwm_d;
      source_period_start <= start_d;
      if (scale_valid) begin
        pend_q <= scale_width;
      end
      if (sink_data_valid) begin
        seen_valid_q <= 1'b1;
      end
      // A fresh command beats a simultaneous period-start increment.
      if (sink_data_valid) begin
        wd_q <= '0;
      end else if (start_d && state_q != StDisarmed && wd_q != WdLimit) begin
        wd_q <= wd_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StDisarmed;
      failsafe <= 1'b0;
    end else begin
      unique case (state_q)
        StDisarmed: begin
          if (sink_arm && (seen_valid_q || sink_data_valid)) begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (!sink_arm) begin
            state_q <= StDisarmed;
          end else if (wd_q == WdLimit) begin
            state_q  <= StFailsafe;
            failsafe <= 1'b1;
          end
        end
        StFailsafe: begin
          if (!sink_arm) begin
            state_q  <= StDisarmed;
            failsafe <= 1'b0;
          end else if (sink_data_valid) begin
            state_q  <= StArmed;
            failsafe <= 1'b0;
          end
        end
        default: begin
          state_q  <= StDisarmed;
          failsafe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_altitude_throttle_pwm.sv
// Scoreboarded bench: stimulus queues the expected high time of each period,
// a monitor measures every completed period and checks it against the queue.
module tb_altitude_throttle_pwm;

  localparam int unsigned Period  = 1000;
  localparam int unsigned MinW    = 400;
  localparam int unsigned MaxW    = 800;
  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sink_data_valid = 1'b0;
  logic [14:0] sink_pid = '0;
  logic        sink_arm = 1'b1;
  logic        pwm_out;
  logic        source_period_start;
  logic        failsafe;

  int exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit in_period = 1'b0;
  int hi_cnt = 0;
  int len_cnt = 0;

  always #5 clk = ~clk;

  altitude_throttle_pwm #(
    .PWM_PERIOD_CYCLES (Period),
    .MIN_PULSE_CYCLES  (MinW),
    .MAX_PULSE_CYCLES  (MaxW),
    .TIMEOUT_PERIODS   (Timeout)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .sink_data_valid     (sink_data_valid),
    .sink_pid            (sink_pid),
    .sink_arm            (sink_arm),
    .pwm_out             (pwm_out),
    .source_period_start (source_period_start),
    .failsafe            (failsafe)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic finish_period();
    int exp;
    if (exp_q.size() == 0) begin
      check("unexpected_period_width", hi_cnt, -1);
    end else begin
      exp = exp_q.pop_front();
      check("pulse_width", hi_cnt, exp);
      check("period_len", len_cnt, int'(Period));
    end
  endtask

  // Monitor: a period is scored when the next period start appears.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_period && exp_q.size() > 0) void'(exp_q.pop_front());
      in_period = 1'b0;
    end else begin
      if (source_period_start) begin
        if (in_period) finish_period();
        in_period = 1'b1;
        hi_cnt = 0;
        len_cnt = 0;
      end
      if (in_period) begin
        len_cnt++;
        if (pwm_out) hi_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (!source_period_start && i < 1100);
    if (!source_period_start) check("period_start_timeout", 0, 1);
  endtask

  task automatic period(input int exp_w);
    wait_start();
    exp_q.push_back(exp_w);
  endtask

  task automatic send(input int pid);
    sink_pid = 15'(pid);
    sink_data_valid = 1'b1;
    step(1);
    sink_data_valid = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    step(3);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(source_period_start), 0);
    check("reset_failsafe", int'(failsafe), 0);
    reset = 1'b1;

    // Armed request but no command yet: stays at minimum throttle.
    period(400); step(10); check("disarmed_failsafe", int'(failsafe), 0);
    period(400);
    period(400); step(10); send(0);

    period(400); step(10); send(16384);
    period(600); step(10); send(32767);
    period(799); step(10); send(16384);

    // Mid-pulse update must wait for the next boundary.
    period(600); step(300); send(32767);

    // Command loss.
    period(799);
    period(799);
    period(799); step(5); check("failsafe_before_timeout", int'(failsafe), 0);
    period(799); step(5); check("failsafe_after_timeout", int'(failsafe), 1);
    period(400); step(10); send(16384); step(4);
    check("failsafe_cleared", int'(failsafe), 0);
    period(600); step(10); send(32767);

    // Disarm mid-period.
    period(799); step(100); sink_arm = 1'b0; step(2);
    check("disarm_failsafe", int'(failsafe), 0);
    period(400); step(10); sink_arm = 1'b1;

    // Asynchronous reset mid-pulse.
    period(799); step(200);
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    reset = 1'b0;
    #1;
    check("async_reset_pwm_out", int'(pwm_out), 0);
    check("async_reset_period_start", int'(source_period_start), 0);
    check("async_reset_failsafe", int'(failsafe), 0);
    step(3);
    reset = 1'b1;
    step(1);
    check("restart_period_start", int'(source_period_start), 1);
    check("restart_pwm_out", int'(pwm_out), 1);
    exp_q.push_back(400);
    period(400);
    wait_start();
    @(negedge clk);
    #1;
    check("periods_scored", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/altitude_throttle_pwm.md
Name: altitude_throttle_pwm

Overview:
- Consumes the altitude PID output (source_data_valid / source_pid[14:0]) and turns it into a standard ESC throttle pulse train driving the drone motors.
- Maps the 15-bit unsigned PID value linearly onto a pulse width between a minimum and a maximum.
- Adopts new widths only at period boundaries, so pulses are never glitched.
- Adds arming control and a command-loss failsafe.

Parameters:
- PWM_PERIOD_CYCLES, 250000, clk cycles per PWM period (2.5 ms / 400 Hz at 100 MHz).
- MIN_PULSE_CYCLES, 100000, high time for zero throttle (1.0 ms).
- MAX_PULSE_CYCLES, 200000, high-time ceiling (2.0 ms).
- TIMEOUT_PERIODS, 8, consecutive periods without a valid update before failsafe.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- sink_data_valid  in  1  one-cycle strobe: sink_pid is valid
- sink_pid  in  15  unsigned throttle command from the PID stage
- sink_arm  in  1  1 = armed, 0 = force minimum throttle
- pwm_out  out  1  ESC pulse output
- source_period_start  out  1  one-cycle pulse on the first cycle of each period
- failsafe  out  1  1 while the command-loss timeout is active

Behaviour:
- Reset (reset=0, async):
  - pwm_out=0, source_period_start=0, failsafe=0.
  - Period counter=0, pending width=active width=MIN_PULSE_CYCLES, watchdog=0, state=DISARMED.
  - On release, the first clk edge begins period 0.
  - Reset asserted mid-pulse drops pwm_out to 0 immediately.
- Period counter:
  - Counts 0..PWM_PERIOD_CYCLES-1, then wraps to 0.
  - source_period_start=1 exactly when counter==0.
  - pwm_out=1 while counter < active width, else 0. Registered output.
- Scaling (2-cycle pipeline):
  - width = MIN + ((sink_pid * (MAX-MIN)) >> 15), with a 32-bit product.
  - Result is clamped to MAX_PULSE_CYCLES; it can never go below MIN.
  - pending width is updated 2 clk after the sink_data_valid cycle.
  - A new valid during the pipeline is accepted every cycle; last one wins.
- Adoption:
  - On the cycle counter==0, the active width loads from the state-selected source:
    - ARMED: pending width.
    - DISARMED or FAILSAFE: MIN_PULSE_CYCLES.
  - Active width is otherwise constant for the whole period; no mid-period change.
  - If pending updates in the same cycle as counter==0, the old pending value is used and the new one applies from the next period.
- State machine (evaluated each cycle, effect visible at the next adoption):
  - DISARMED -> ARMED: sink_arm=1 and at least one valid received since reset.
  - ARMED -> DISARMED: sink_arm=0. Has priority over failsafe.
  - ARMED -> FAILSAFE: watchdog reaches TIMEOUT_PERIODS. Watchdog increments on each counter==0 and clears on sink_data_valid; a clear and an increment in the same cycle resolve to 0.
  - FAILSAFE -> ARMED: a sink_data_valid arrives while sink_arm=1.
  - FAILSAFE -> DISARMED: sink_arm=0.
  - failsafe output is 1 exactly in the FAILSAFE state.
- Watchdog saturates at TIMEOUT_PERIODS and is not incremented in DISARMED.
- Parameters require MIN < MAX < PWM_PERIOD_CYCLES; the implementation rejects anything else at elaboration.

Decomposition:
- Shared package pid_pwm_pkg:
  - state enum DISARMED/ARMED/FAILSAFE.
  - Widths: PID_W=15, CNT_W=18, PROD_W=32.
  - Default timing constants.
- One sub-module, pwm_scale: the 2-stage multiply/shift/clamp pipeline with valid in/out.
- Counter, watchdog and FSM stay in the top module.

Test Plan:
All scenarios use PWM_PERIOD_CYCLES=1000, MIN=400, MAX=800, TIMEOUT_PERIODS=4.
1. Reset release, no valid, sink_arm=1 -> state stays DISARMED; pwm_out high 400 cycles per 1000; source_period_start every 1000 cycles; failsafe=0.
2. Armed, valid sink_pid=0 / 16384 / 32767 in consecutive periods -> next-period high times 400 / 600 / 799 cycles.
3. Armed at 600, valid sink_pid=32767 at counter=300 (mid-pulse) -> current pulse stays 600 cycles; following period 799.
4. Armed at 799, no valid for 4 periods -> failsafe=1 after the 4th period start; next period 400 cycles. Valid sink_pid=16384 -> failsafe=0, next period 600.
5. Armed at 799, sink_arm=0 at counter=100 -> current pulse completes at 799; next period 400; state DISARMED.
6. Armed, reset=0 at counter=200 while pwm_out=1 -> pwm_out=0 immediately. After release: period restarts at counter 0 with 400-cycle pulse, state DISARMED, failsafe=0.
